ifetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined RISC-V core. It owns the fetch PC, issues one read per cycle to a synchronous instruction memory, buffers returned instructions with their PCs in a DEPTH-entry prefetch queue, and hands them to decode over a valid/ready handshake. It replaces the single IF/ID register. A redirect from EX (taken branch, JAL, JALR) flushes the queue and cancels any in-flight fetch.

---
 rtl/riscv_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/ifetch_queue.sv | 84 ++++++++
 tb/tb_ifetch_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared core constants for the pipelined RISC-V core.
package riscv_pkg;

    localparam int          XLEN     = 32;
    localparam int          INSTR_W  = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} entries for the fetch front end.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem read per cycle
// and buffers returned instructions in a prefetch queue for decode.
module ifetch_queue #(
    parameter int                XLEN     = riscv_pkg::XLEN,
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RESET_PC = riscv_pkg::RESET_PC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [riscv_pkg::INSTR_W-1:0] imem_rdata,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [XLEN-1:0]              dec_pc,
    output logic [riscv_pkg::INSTR_W-1:0] dec_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int INSTR_W = riscv_pkg::INSTR_W;
    localparam int ENTRY_W = XLEN + INSTR_W;

    logic [XLEN-1:0]    fetch_pc;
    logic [XLEN-1:0]    inflight_pc;
    logic               inflight;
    logic               kill;
    logic [CNT_W:0]     credit;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_data;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // Entries already queued plus the one still in flight must fit, so a
    // return can always be pushed without overflowing.
    assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign imem_req  = ~rst & ~redirect_valid & (credit < (CNT_W+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign push      = inflight & ~kill;
    assign dec_valid = (count != '0) & ~redirect_valid & ~rst;
    assign pop       = dec_valid & dec_ready;
    assign dec_pc    = head_data[ENTRY_W-1:INSTR_W];
    assign dec_instr = head_data[INSTR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            kill     <= 1'b1;
        end else begin
            kill     <= 1'b0;
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_valid),
        .push      (push),
        .push_data ({inflight_pc, imem_rdata}),
        .pop       (pop),
        .head_data (head_data),
        .count     (count)
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: scoreboard of expected decode PCs plus
// cycle-exact checks of issue, stall, redirect, reset and PC wrap behaviour.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;
    logic [2:0]  count;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        dec_valid_w;
    logic [31:0] dec_pc_w;
    logic [31:0] dec_instr_w;
    logic [2:0]  count_w;

    int          total  = 0;
    int          passed = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Memory models: main instance returns the address, wrap instance its inverse.
    always @(posedge clk) begin
        imem_rdata   <= imem_addr;
        imem_rdata_w <= ~imem_addr_w;
    end

    ifetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr),
        .count          (count)
    );

    ifetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_rdata     (imem_rdata_w),
        .dec_valid      (dec_valid_w),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc_w),
        .dec_instr      (dec_instr_w),
        .count          (count_w)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic loadExpect(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    // Every accepted head must be the next PC of the expected stream.
    task automatic scoreboardPop();
        logic [31:0] e;
        if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
            checkOutput("sb_has_expect", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_pc", dec_pc, e);
                checkOutput("sb_instr", dec_instr, e);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        scoreboardPop();
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b1;

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("rst_imem_req", imem_req, 32'd0);
        checkOutput("rst_dec_valid", dec_valid, 32'd0);
        checkOutput("rst_count", count, 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_imem_addr_wrap", imem_addr_w, 32'hFFFF_FFF8);
        checkOutput("rst_imem_req_wrap", imem_req_w, 32'd0);

        $display("[TB] streaming from reset");
        loadExpect(32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            checkOutput("stream_req", imem_req, 32'd1);
            checkOutput("stream_addr", imem_addr, 32'(4 * i));
            checkOutput("stream_dec_valid", dec_valid, (i >= 2) ? 32'd1 : 32'd0);
            checkOutput("stream_count", count, (i >= 2) ? 32'd1 : 32'd0);
            checkOutput("wrap_addr", imem_addr_w, 32'hFFFF_FFF8 + 32'(4 * i));
            if (i >= 2) begin
                checkOutput("wrap_dec_pc", dec_pc_w, 32'hFFFF_FFF8 + 32'(4 * (i - 2)));
                checkOutput("wrap_dec_instr", dec_instr_w, ~(32'hFFFF_FFF8 + 32'(4 * (i - 2))));
            end
        end

        $display("[TB] decode stall");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
            if (k == 0) begin
                checkOutput("stall0_req", imem_req, 32'd1);
                checkOutput("stall0_count", count, 32'd1);
            end
            if (k == 3) begin
                checkOutput("stall3_req", imem_req, 32'd0);
                checkOutput("stall3_addr", imem_addr, 32'd40);
            end
            if (k == 9) begin
                checkOutput("stall9_count", count, 32'd4);
                checkOutput("stall9_req", imem_req, 32'd0);
                checkOutput("stall9_dec_valid", dec_valid, 32'd1);
                checkOutput("stall9_dec_pc", dec_pc, 32'd24);
            end
        end

        $display("[TB] release stall");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
            if (k == 0) begin
                checkOutput("release0_req", imem_req, 32'd0);
            end
            if (k == 1) begin
                checkOutput("release1_req", imem_req, 32'd1);
                checkOutput("release1_addr", imem_addr, 32'd40);
            end
        end

        $display("[TB] redirect with full pipeline");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        checkOutput("redir_count_before", count, 32'd3);
        checkOutput("redir_dec_valid", dec_valid, 32'd0);
        checkOutput("redir_req", imem_req, 32'd0);
        loadExpect(32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir1_count", count, 32'd0);
        checkOutput("redir1_dec_valid", dec_valid, 32'd0);
        checkOutput("redir1_req", imem_req, 32'd1);
        checkOutput("redir1_addr", imem_addr, 32'h0000_0100);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir2_dec_valid", dec_valid, 32'd0);
        checkOutput("redir2_addr", imem_addr, 32'h0000_0104);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("redir3_dec_valid", dec_valid, 32'd1);
        checkOutput("redir3_dec_pc", dec_pc, 32'h0000_0100);
        checkOutput("redir3_dec_instr", dec_instr, 32'h0000_0100);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        end

        $display("[TB] reset mid-stream");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        checkOutput("midrst_count_before", count, 32'd2);
        checkOutput("midrst_req", imem_req, 32'd0);
        checkOutput("midrst_dec_valid", dec_valid, 32'd0);
        loadExpect(32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("postrst_count", count, 32'd0);
        checkOutput("postrst_dec_valid", dec_valid, 32'd0);
        checkOutput("postrst_addr", imem_addr, 32'h0);
        checkOutput("postrst_req", imem_req, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("postrst1_dec_valid", dec_valid, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("postrst2_dec_valid", dec_valid, 32'd1);
        checkOutput("postrst2_dec_pc", dec_pc, 32'h0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        end
        scoreboardPop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
